// File: rtl/date_sequencer_pkg.sv
// Shared definitions for the date sequencer: FSM state encoding, month
// lengths for the Jan..Apr window and the month output encodings.
package date_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STEP} stateT;

  localparam int DAYS_JAN    = 31;
  localparam int DAYS_FEB    = 28;
  localparam int DAYS_MAR    = 31;
  localparam int DAYS_APR    = 30;
  localparam int MAX_NONLEAP = DAYS_JAN + DAYS_FEB + DAYS_MAR + DAYS_APR;  // 120

  localparam logic [1:0] MON_JAN = 2'd0;
  localparam logic [1:0] MON_FEB = 2'd1;
  localparam logic [1:0] MON_MAR = 2'd2;
  localparam logic [1:0] MON_APR = 2'd3;

  // Last legal day-of-year; leap years push everything after Feb 28 by one.
  function automatic logic [6:0] maxDate(input logic leap);
    return leap ? 7'(MAX_NONLEAP + 1) : 7'(MAX_NONLEAP);
  endfunction

endpackage

// File: rtl/date_sequencer_dateconverter.sv
// dateconverter: combinational day-of-year to month / BCD day-of-month.
//   date     in  7  day-of-year, 1-based, 1..121
//   leapYear in  1  1 = February has 29 days
//   month    out 2  0=Jan .. 3=Apr
//   dayOnes  out 4  BCD ones digit of day-of-month
//   dayTens  out 2  tens digit of day-of-month
module dateconverter
  import date_sequencer_pkg::*;
(
  input  logic [6:0] date,
  input  logic       leapYear,
  output logic [1:0] month,
  output logic [3:0] dayOnes,
  output logic [1:0] dayTens
);

  logic [6:0] febEnd, marEnd, dom;

  always_comb begin
    febEnd = 7'(DAYS_JAN + DAYS_FEB) + {6'd0, leapYear};
    marEnd = febEnd + 7'(DAYS_MAR);
    if (date <= 7'(DAYS_JAN)) begin
      month = MON_JAN;
      dom   = date;
    end else if (date <= febEnd) begin
      month = MON_FEB;
      dom   = date - 7'(DAYS_JAN);
    end else if (date <= marEnd) begin
      month = MON_MAR;
      dom   = date - febEnd;
    end else begin
      month = MON_APR;
      dom   = date - marEnd;
    end

    // Day-of-month never exceeds 31, so a compare ladder replaces a divider.
    if (dom >= 7'd30) begin
      dayTens = 2'd3;
      dayOnes = 4'(dom - 7'd30);
    end else if (dom >= 7'd20) begin
      dayTens = 2'd2;
      dayOnes = 4'(dom - 7'd20);
    end else if (dom >= 7'd10) begin
      dayTens = 2'd1;
      dayOnes = 4'(dom - 7'd10);
    end else begin
      dayTens = 2'd0;
      dayOnes = 4'(dom);
    end
  end

endmodule

// File: rtl/date_sequencer.sv
// date_sequencer: day-of-year counter for Jan..Apr, advanced automatically
// (RUN, once per prescaler tick) or one day per step key press (STEP).
//   clk        in  1  clock, rising edge
//   reset_n    in  1  asynchronous active-low reset
//   run        in  1  level, auto-advance enable
//   step       in  1  debounced key level; rising edge = single advance
//   dir        in  1  0 = next day, 1 = previous day
//   leap_year  in  1  1 = February has 29 days
//   load       in  1  strobe, loads load_date (clamped to 1..MAX)
//   load_date  in  7  day-of-year to load
//   date       out 7  current day-of-year, zero extra latency
//   month      out 2  registered converter output
//   day_tens   out 2  registered converter output
//   day_ones   out 4  registered converter output (BCD)
//   wrap       out 1  pulse with the first cycle of a wrapped date
//   busy       out 1  1 while in RUN
module date_sequencer
  import date_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  input  logic       leap_year,
  input  logic       load,
  input  logic [6:0] load_date,
  output logic [6:0] date,
  output logic [1:0] month,
  output logic [1:0] day_tens,
  output logic [3:0] day_ones,
  output logic       wrap,
  output logic       busy
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] TERM = PW'(CLK_DIV - 1);

  stateT         state;
  logic [PW-1:0] presc;
  logic          stepPrev;
  logic [6:0]    maxD, advDate, loadVal;
  logic          advWrap, stepRise, tick, doAdv;
  logic [1:0]    convMonth, convTens;
  logic [3:0]    convOnes;

  assign maxD     = maxDate(leap_year);
  assign stepRise = step & ~stepPrev;
  assign tick     = (state == RUN) && (presc == TERM);
  // STEP lasts exactly one cycle, so being in it is the single advance.
  assign doAdv    = tick || (state == STEP);
  assign busy     = (state == RUN);

  always_comb begin
    advDate = date;
    advWrap = 1'b0;
    if (!dir) begin
      if (date >= maxD) begin
        advDate = 7'd1;
        advWrap = 1'b1;
      end else begin
        advDate = date + 7'd1;
      end
    end else begin
      if (date <= 7'd1) begin
        advDate = maxD;
        advWrap = 1'b1;
      end else begin
        advDate = date - 7'd1;
      end
    end

    if (load_date == 7'd0)     loadVal = 7'd1;
    else if (load_date > maxD) loadVal = maxD;
    else                       loadVal = load_date;
  end

  dateconverter uConv (
    .date     (date),
    .leapYear (leap_year),
    .month    (convMonth),
    .dayOnes  (convOnes),
    .dayTens  (convTens)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      stepPrev <= 1'b0;
      date     <= 7'd1;
      wrap     <= 1'b0;
      month    <= MON_JAN;
      day_tens <= 2'd0;
      day_ones <= 4'd1;
    end else begin
      stepPrev <= step;
      wrap     <= 1'b0;

      // Load never alters the state sequence; it only overrides the date.
      case (state)
        IDLE: begin
          presc <= '0;
          if (run)           state <= RUN;
          else if (stepRise) state <= STEP;
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + 1'b1;
          end
        end
        STEP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Priority: load, then leap-year clamp (day 121 vanishing), then advance.
      if (load) begin
        date <= loadVal;
      end else if (date > maxD) begin
        date <= maxD;
      end else if (doAdv) begin
        date <= advDate;
        wrap <= advWrap;
      end

      month    <= convMonth;
      day_tens <= convTens;
      day_ones <= convOnes;
    end
  end

endmodule

// File: tb/tb_date_sequencer.sv
module tb_date_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, run, step, dir, leap_year, load;
  logic [6:0] load_date;
  logic [6:0] date;
  logic [1:0] month, day_tens;
  logic [3:0] day_ones;
  logic       wrap, busy;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  date_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .dir(dir),
    .leap_year(leap_year), .load(load), .load_date(load_date),
    .date(date), .month(month), .day_tens(day_tens), .day_ones(day_ones),
    .wrap(wrap), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; run = 0; step = 0; dir = 0; leap_year = 0; load = 0; load_date = 7'd0;
    #12;
    chk("rst_date",  32'(date), 32'd1);
    chk("rst_month", 32'(month), 32'd0);
    chk("rst_tens",  32'(day_tens), 32'd0);
    chk("rst_ones",  32'(day_ones), 32'd1);
    chk("rst_wrap",  32'(wrap), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(date), 32'd1);

    // Jan 31 -> Feb 1 via a single step
    load = 1; load_date = 7'd31; cyc(); load = 0;
    chk("ld31", 32'(date), 32'd31);
    step = 1; cyc();
    chk("step_pending", 32'(date), 32'd31);
    cyc();
    chk("step32", 32'(date), 32'd32);
    chk("conv_lag_tens", 32'(day_tens), 32'd3);
    step = 0; cyc();
    chk("m32_month", 32'(month), 32'd1);
    chk("m32_tens",  32'(day_tens), 32'd0);
    chk("m32_ones",  32'(day_ones), 32'd1);

    // day 60, non-leap -> Mar 1
    load = 1; load_date = 7'd59; cyc(); load = 0;
    step = 1; cyc(); cyc();
    chk("nl60_date", 32'(date), 32'd60);
    step = 0; cyc();
    chk("nl60_month", 32'(month), 32'd2);
    chk("nl60_tens",  32'(day_tens), 32'd0);
    chk("nl60_ones",  32'(day_ones), 32'd1);

    // day 60, leap -> Feb 29
    leap_year = 1;
    load = 1; load_date = 7'd59; cyc(); load = 0;
    step = 1; cyc(); cyc();
    chk("lp60_date", 32'(date), 32'd60);
    step = 0; cyc();
    chk("lp60_month", 32'(month), 32'd1);
    chk("lp60_tens",  32'(day_tens), 32'd2);
    chk("lp60_ones",  32'(day_ones), 32'd9);

    // RUN wrap from 120 with CLK_DIV=4
    leap_year = 0;
    load = 1; load_date = 7'd120; cyc(); load = 0;
    run = 1; cyc();
    chk("run_busy0", 32'(busy), 32'd1);
    cyc(); cyc(); cyc();
    chk("run_pre_tick", 32'(date), 32'd120);
    chk("run_busy1", 32'(busy), 32'd1);
    cyc();
    chk("run_wrap_date", 32'(date), 32'd1);
    chk("run_wrap_pulse", 32'(wrap), 32'd1);
    chk("run_busy2", 32'(busy), 32'd1);
    cyc();
    chk("run_wrap_clear", 32'(wrap), 32'd0);
    chk("run_hold", 32'(date), 32'd1);
    // load coincident with the next tick: load wins
    cyc(); cyc();
    load = 1; load_date = 7'd50; cyc(); load = 0;
    chk("ld_vs_tick", 32'(date), 32'd50);
    chk("ld_vs_tick_wrap", 32'(wrap), 32'd0);
    cyc();
    chk("ld_vs_tick_hold", 32'(date), 32'd50);
    run = 0; cyc();
    chk("run_exit_busy", 32'(busy), 32'd0);

    // backward wrap in a leap year, then leap_year falls
    dir = 1; leap_year = 1;
    load = 1; load_date = 7'd1; cyc(); load = 0;
    step = 1; cyc(); cyc();
    chk("bk_wrap_date", 32'(date), 32'd121);
    chk("bk_wrap_pulse", 32'(wrap), 32'd1);
    step = 0; leap_year = 0; cyc();
    chk("clamp_date", 32'(date), 32'd120);
    chk("clamp_wrap", 32'(wrap), 32'd0);

    // load clamping
    dir = 0;
    load = 1; load_date = 7'd0; cyc();
    chk("ld0", 32'(date), 32'd1);
    load_date = 7'd127; cyc();
    chk("ld127_nl", 32'(date), 32'd120);
    leap_year = 1; cyc(); load = 0;
    chk("ld127_lp", 32'(date), 32'd121);

    // step ignored in RUN, then async reset mid-prescale
    leap_year = 0;
    load = 1; load_date = 7'd100; cyc(); load = 0;
    run = 1; cyc();
    step = 1; cyc();
    chk("run_step_ign", 32'(date), 32'd100);
    reset_n = 1'b0; #1;
    chk("arst_date",  32'(date), 32'd1);
    chk("arst_month", 32'(month), 32'd0);
    chk("arst_tens",  32'(day_tens), 32'd0);
    chk("arst_ones",  32'(day_ones), 32'd1);
    chk("arst_wrap",  32'(wrap), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    cyc();
    chk("arst_hold", 32'(date), 32'd1);
    run = 0; step = 0;
    reset_n = 1'b1; cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wrap", 32'(wrap), 32'd0);
    chk("post_rst_date", 32'(date), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
